// File: rtl/ball_ctrl_p.sv
// ball_ctrl_p: square ball sprite with parametrised size and start state.
// Draws a (2*HALF+1)-pixel square around (xloc, yloc), records the 1-pixel
// neighbour ring from the VGA scan, and bounces off non-empty pixels.
// Every bounce speeds the ball up by lowering the move divider.
//
// Ports:
//   clk, rst           system clock, async active-high reset
//   pixpulse           pixel enable; every state change is gated by it
//   hcount, vcount     current scan position
//   empty              current scan pixel is background
//   move               frame-rate move strobe (only seen with pixpulse)
//   draw_ball          scan position lies inside the ball (combinational)
//   xloc, yloc         ball centre
//   xdir, ydir         direction (1 = right / down)
//   bounce             one-pixpulse pulse on a step that reversed an axis
//   bounce_cnt         saturating bounce count
//   period             current move divider
module ball_ctrl_p #(
    parameter int HALF         = 10,
    parameter int XLOC_START   = 320,
    parameter int YLOC_START   = 240,
    parameter int XDIR_START   = 1,
    parameter int YDIR_START   = 1,
    parameter int PERIOD_START = 4,
    parameter int PERIOD_MIN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       empty,
    input  logic       move,
    output logic       draw_ball,
    output logic [9:0] xloc,
    output logic [9:0] yloc,
    output logic       xdir,
    output logic       ydir,
    output logic       bounce,
    output logic [7:0] bounce_cnt,
    output logic [3:0] period
);
    localparam int W  = 2 * HALF + 3;
    localparam int H1 = HALF + 1;
    localparam logic [10:0] HALF11 = 11'(HALF);

    logic [W-1:0] occ_lft, occ_rgt, occ_top, occ_bot;
    logic [W-1:0] hit_lft, hit_rgt, hit_top, hit_bot;
    logic [3:0]   div_cnt;
    logic         clear_pending;

    // 11-bit sums so the ball edges never wrap near the screen border
    logic [10:0] hc11, vc11, xl11, yl11;
    assign hc11 = {1'b0, hcount};
    assign vc11 = {1'b0, vcount};
    assign xl11 = {1'b0, xloc};
    assign yl11 = {1'b0, yloc};

    assign draw_ball = (hc11 + HALF11 >= xl11) && (hc11 <= xl11 + HALF11) &&
                       (vc11 + HALF11 >= yl11) && (vc11 <= yl11 + HALF11);

    // Ring hit decode; the per-bit compare keeps out-of-range indices unwritten
    int dx, dy;
    always_comb begin
        hit_lft = '0;
        hit_rgt = '0;
        hit_top = '0;
        hit_bot = '0;
        dx = int'(hcount) - int'(xloc);
        dy = int'(vcount) - int'(yloc);
        if (!empty) begin
            if (dy >= -H1 && dy <= H1) begin
                for (int i = 0; i < W; i++) begin
                    if (i == H1 - dy) begin
                        hit_rgt[i] = (dx == H1);
                        hit_lft[i] = (dx == -H1);
                    end
                end
            end
            if (dx >= -H1 && dx <= H1) begin
                for (int i = 0; i < W; i++) begin
                    if (i == H1 - dx) begin
                        hit_bot[i] = (dy == H1);
                        hit_top[i] = (dy == -H1);
                    end
                end
            end
        end
    end

    // Side rings: LSB = bottom; top/bottom rings: LSB = right
    logic rgt_up, rgt_dn, lft_up, lft_dn, top_lft, top_rgt, bot_lft, bot_rgt;
    assign rgt_up  = |occ_rgt[W-2:2];
    assign rgt_dn  = |occ_rgt[W-3:1];
    assign lft_up  = |occ_lft[W-2:2];
    assign lft_dn  = |occ_lft[W-3:1];
    assign top_lft = |occ_top[W-2:2];
    assign top_rgt = |occ_top[W-3:1];
    assign bot_lft = |occ_bot[W-2:2];
    assign bot_rgt = |occ_bot[W-3:1];

    logic x_blk, y_blk, corner_bit, corner, rev_x, rev_y, rev_any;
    logic nxt_xdir, nxt_ydir, div_expire;

    assign x_blk = xdir ? (ydir ? rgt_dn : rgt_up) : (ydir ? lft_dn : lft_up);
    assign y_blk = ydir ? (xdir ? bot_rgt : bot_lft) : (xdir ? top_rgt : top_lft);
    // Diagonal corner pixel only counts when nothing else blocks the ball
    assign corner_bit = xdir ? (ydir ? occ_rgt[0] : occ_rgt[W-1])
                             : (ydir ? occ_lft[0] : occ_lft[W-1]);
    assign corner   = corner_bit & ~x_blk & ~y_blk;
    assign rev_x    = x_blk | corner;
    assign rev_y    = y_blk | corner;
    assign rev_any  = rev_x | rev_y;
    assign nxt_xdir = xdir ^ rev_x;
    assign nxt_ydir = ydir ^ rev_y;

    assign div_expire = (div_cnt + 4'd1 == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xloc          <= 10'(XLOC_START);
            yloc          <= 10'(YLOC_START);
            xdir          <= 1'(XDIR_START);
            ydir          <= 1'(YDIR_START);
            period        <= 4'(PERIOD_START);
            div_cnt       <= '0;
            bounce        <= 1'b0;
            bounce_cnt    <= '0;
            occ_lft       <= '0;
            occ_rgt       <= '0;
            occ_top       <= '0;
            occ_bot       <= '0;
            clear_pending <= 1'b0;
        end else if (pixpulse) begin
            bounce        <= 1'b0;
            clear_pending <= move & div_expire;
            if (move) begin
                if (div_expire) begin
                    div_cnt <= '0;
                    xdir    <= nxt_xdir;
                    ydir    <= nxt_ydir;
                    xloc    <= nxt_xdir ? xloc + 10'd1 : xloc - 10'd1;
                    yloc    <= nxt_ydir ? yloc + 10'd1 : yloc - 10'd1;
                    bounce  <= rev_any;
                    if (rev_any) begin
                        if (bounce_cnt != 8'hFF)
                            bounce_cnt <= bounce_cnt + 8'd1;
                        if (period > 4'(PERIOD_MIN))
                            period <= period - 4'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
            end
            // Rings describe the old position after a step: flush them once
            if (clear_pending) begin
                occ_lft <= '0;
                occ_rgt <= '0;
                occ_top <= '0;
                occ_bot <= '0;
            end else begin
                occ_lft <= occ_lft | hit_lft;
                occ_rgt <= occ_rgt | hit_rgt;
                occ_top <= occ_top | hit_top;
                occ_bot <= occ_bot | hit_bot;
            end
        end
    end
endmodule

// File: tb/tb_ball_ctrl_p.sv
module tb_ball_ctrl_p;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       empty = 1'b1;
    logic       move = 1'b0;

    logic       draw_ball, xdir, ydir, bounce;
    logic [9:0] xloc, yloc;
    logic [7:0] bounce_cnt;
    logic [3:0] period;

    logic       f_draw_ball, f_xdir, f_ydir, f_bounce;
    logic [9:0] f_xloc, f_yloc;
    logic [7:0] f_bounce_cnt;
    logic [3:0] f_period;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ball_ctrl_p dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .draw_ball(draw_ball), .xloc(xloc), .yloc(yloc),
        .xdir(xdir), .ydir(ydir), .bounce(bounce), .bounce_cnt(bounce_cnt), .period(period)
    );

    ball_ctrl_p #(.PERIOD_START(1)) dut_f (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
        .empty(empty), .move(move), .draw_ball(f_draw_ball), .xloc(f_xloc), .yloc(f_yloc),
        .xdir(f_xdir), .ydir(f_ydir), .bounce(f_bounce), .bounce_cnt(f_bounce_cnt),
        .period(f_period)
    );

    task automatic pulse(input int h, input int v, input logic e, input logic mv);
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); empty = e; move = mv; pixpulse = 1'b1;
        @(posedge clk);
        #1;
        pixpulse = 1'b0; move = 1'b0; empty = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_pos(input string name, input logic [9:0] ex, input logic [9:0] ey);
        total++;
        if (xloc !== ex || yloc !== ey) begin
            bad++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", name, xloc, yloc, ex, ey);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_pos("reset_pos", 10'd320, 10'd240);
        total++;
        if ({xdir, ydir, bounce, bounce_cnt, period} !== {1'b1, 1'b1, 1'b0, 8'd0, 4'd4}) begin
            bad++;
            $display("FAIL reset_state: got dir=%b%b b=%b cnt=%0d per=%0d want 11 0 0 4",
                     xdir, ydir, bounce, bounce_cnt, period);
        end
        total++;
        if (f_period !== 4'd1) begin
            bad++;
            $display("FAIL reset_period_f: got %0d want 1", f_period);
        end
    endtask

    task automatic test_draw();
        logic [3:0] got;
        @(negedge clk);
        hcount = 10'd310; vcount = 10'd240; #1; got[0] = draw_ball;
        hcount = 10'd309;                   #1; got[1] = draw_ball;
        hcount = 10'd330; vcount = 10'd250; #1; got[2] = draw_ball;
        hcount = 10'd320; vcount = 10'd251; #1; got[3] = draw_ball;
        total++;
        if (got !== 4'b0101) begin
            bad++;
            $display("FAIL draw_ball: got %b want 0101", got);
        end
    endtask

    task automatic test_open_fast();
        logic seen;
        seen = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(0, 0, 1'b1, 1'b1);
            seen |= f_bounce;
        end
        total++;
        if (f_xloc !== 10'd325 || f_yloc !== 10'd245) begin
            bad++;
            $display("FAIL open_fast_pos: got (%0d,%0d) want (325,245)", f_xloc, f_yloc);
        end
        total++;
        if (seen !== 1'b0 || f_bounce_cnt !== 8'd0) begin
            bad++;
            $display("FAIL open_fast_bounce: got seen=%b cnt=%0d want 0 0", seen, f_bounce_cnt);
        end
        check_pos("open_slow_5", 10'd321, 10'd241);
    endtask

    task automatic test_divider();
        do_reset();
        @(negedge clk);
        move = 1'b1;
        repeat (3) @(negedge clk);
        move = 1'b0;
        #1;
        check_pos("move_no_pix", 10'd320, 10'd240);
        for (int i = 0; i < 8; i++) pulse(0, 0, 1'b1, 1'b1);
        check_pos("divider_8", 10'd322, 10'd242);
    endtask

    task automatic test_wall();
        do_reset();
        for (int v = 200; v <= 280; v++) pulse(331, v, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1'b1, 1'b1);
        check_pos("wall_pre", 10'd320, 10'd240);
        pulse(0, 0, 1'b1, 1'b1);
        check_pos("wall_pos", 10'd319, 10'd241);
        total++;
        if ({xdir, ydir, bounce, bounce_cnt, period} !== {1'b0, 1'b1, 1'b1, 8'd1, 4'd3}) begin
            bad++;
            $display("FAIL wall_state: got dir=%b%b b=%b cnt=%0d per=%0d want 01 1 1 3",
                     xdir, ydir, bounce, bounce_cnt, period);
        end
        @(posedge clk);
        #1;
        total++;
        if (bounce !== 1'b1) begin
            bad++;
            $display("FAIL bounce_hold: got %b want 1", bounce);
        end
        // clearing pulse; its ring write (a pixel left of the ball) is dropped
        pulse(308, 241, 1'b0, 1'b0);
        total++;
        if (bounce !== 1'b0) begin
            bad++;
            $display("FAIL bounce_drop: got %b want 0", bounce);
        end
        for (int i = 0; i < 3; i++) pulse(0, 0, 1'b1, 1'b1);
        check_pos("after_clear", 10'd318, 10'd242);
        total++;
        if (xdir !== 1'b0 || bounce_cnt !== 8'd1) begin
            bad++;
            $display("FAIL after_clear_state: got xdir=%b cnt=%0d want 0 1", xdir, bounce_cnt);
        end
    endtask

    task automatic test_corner();
        do_reset();
        pulse(331, 251, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pulse(0, 0, 1'b1, 1'b1);
        check_pos("corner_pos", 10'd319, 10'd239);
        total++;
        if ({xdir, ydir, bounce, bounce_cnt} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL corner_state: got dir=%b%b b=%b cnt=%0d want 00 1 1",
                     xdir, ydir, bounce, bounce_cnt);
        end
    endtask

    task automatic test_saturate();
        int mx, my, per, hits;
        logic mxd;
        mx = 320; my = 240; mxd = 1'b1; per = 4; hits = 0;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            pulse(0, 0, 1'b1, 1'b0);
            pulse(mxd ? mx + 11 : mx - 11, my, 1'b0, 1'b0);
            for (int k = 0; k < per; k++) pulse(0, 0, 1'b1, 1'b1);
            if (bounce === 1'b1) hits++;
            mxd = ~mxd;
            mx  = mxd ? mx + 1 : mx - 1;
            my  = my + 1;
            if (per > 1) per--;
        end
        total++;
        if (hits != 300) begin
            bad++;
            $display("FAIL sat_pulses: got %0d want 300", hits);
        end
        check_pos("sat_pos", 10'(mx), 10'(my));
        total++;
        if (bounce_cnt !== 8'd255 || period !== 4'd1) begin
            bad++;
            $display("FAIL sat_state: got cnt=%0d per=%0d want 255 1", bounce_cnt, period);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int v = 200; v <= 280; v++) pulse(331, v, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1'b1, 1'b1);
        @(negedge clk);
        hcount = 10'd0; vcount = 10'd0; empty = 1'b1; move = 1'b1; pixpulse = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_pos("rst_async", 10'd320, 10'd240);
        @(posedge clk);
        #1;
        pixpulse = 1'b0; move = 1'b0;
        total++;
        if ({xdir, ydir, bounce, bounce_cnt, period} !== {1'b1, 1'b1, 1'b0, 8'd0, 4'd4}) begin
            bad++;
            $display("FAIL rst_mid_state: got dir=%b%b b=%b cnt=%0d per=%0d want 11 0 0 4",
                     xdir, ydir, bounce, bounce_cnt, period);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) pulse(0, 0, 1'b1, 1'b1);
        check_pos("rst_rings_clear", 10'd321, 10'd241);
        total++;
        if (bounce !== 1'b0 || xdir !== 1'b1) begin
            bad++;
            $display("FAIL rst_rings_state: got b=%b xdir=%b want 0 1", bounce, xdir);
        end
    endtask

    initial begin
        test_reset();
        test_draw();
        test_open_fast();
        test_divider();
        test_wall();
        test_corner();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ball_ctrl_p.md
# ball_ctrl_p

Parametrised successor of the fixed-size square ball controller: draws a square ball of configurable half-width, tracks the 1-pixel neighbour ring from the VGA pixel scan, and bounces off any non-empty pixel. New over the previous generation: configurable size and start state, a per-ball move divider that speeds the ball up on every bounce, a saturating bounce counter, and a bounce event pulse for the score/sound logic. Sits beside the other sprite blocks, fed by the VGA timing generator's `hcount`/`vcount`/`pixpulse` and the frame-rate `move` strobe.

## Interface
- HALF, 10: ball half-width; ball spans xloc±HALF, yloc±HALF; legal 1..30
- XLOC_START, 320: reset x-location
- YLOC_START, 240: reset y-location
- XDIR_START, 1: reset x direction (1 = right)
- YDIR_START, 1: reset y direction (1 = down)
- PERIOD_START, 4: reset move divider (ball steps once per PERIOD move strobes); legal 1..15
- PERIOD_MIN, 1: floor for the divider after speed-ups
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- pixpulse  in  1  pixel enable, one clk in four; all state changes gated by it
- hcount  in  10  current scan x (0 left .. 639)
- vcount  in  10  current scan y (0 top .. 479)
- empty  in  1  current scan pixel is background
- move  in  1  move strobe, sampled only when pixpulse high
- draw_ball  out  1  combinational: scan position inside the ball
- xloc, yloc  out  10 each  ball centre
- xdir, ydir  out  1 each  current direction
- bounce  out  1  one-pixpulse pulse on a step that reverses either axis
- bounce_cnt  out  8  saturating bounce count
- period  out  4  current move divider

## Operation
- draw_ball = hcount+HALF ≥ xloc & hcount ≤ xloc+HALF & same for v; all sums 11-bit, no wrap.
- Neighbour rings: four vectors occ_lft/rgt/top/bot, width W=2·HALF+3. On pixpulse & ~empty & ~clear_pending: if |vcount−yloc| ≤ HALF+1 and hcount = xloc+HALF+1 set occ_rgt[yloc−vcount+HALF+1]; hcount = xloc−HALF−1 sets occ_lft likewise (LSB = bottom). If |hcount−xloc| ≤ HALF+1 and vcount = yloc+HALF+1 set occ_bot[xloc−hcount+HALF+1]; vcount = yloc−HALF−1 sets occ_top (LSB = right). Out-of-range indices never written.
- Blocked terms: side-up = |occ_side[W−2:2], side-dn = |occ_side[W−3:1]; top/bot lft = |[W−2:2], rgt = |[W−3:1]. Corner terms: corner bit ([W−1] up, [0] down) set and both adjacent blocked terms clear.
- Divider: div_cnt counts move strobes; when div_cnt+1 = period, div_cnt←0 and a step occurs, else div_cnt increments only.
- Step (per {xdir,ydir}): axis blocked (side term or matching corner) → reverse dir and move 1 pixel away; else move 1 pixel in dir. Corner hit reverses both axes.
- Any reversal on a step: bounce=1, bounce_cnt+1 (saturate 255), period−1 if period > PERIOD_MIN.
- After every step, clear_pending=1; next pixpulse clears all rings and clears the flag.

## Timing
- Reset: xloc=XLOC_START, yloc=YLOC_START, xdir=XDIR_START, ydir=YDIR_START, period=PERIOD_START, div_cnt=0, bounce=0, bounce_cnt=0, rings=0, clear_pending=0.
- Position/dir/bounce update on the clk edge where pixpulse & move & divider expires; bounce held until the next pixpulse edge, then 0.
- Ring clear occurs on the pixpulse after the step; ring writes on that pixpulse are dropped.
- move without pixpulse ignored; strobes without a step do not clear rings.
- Reset mid-frame: all state returns to reset values immediately; scan resumes with empty rings.

## Test plan
- Open field, PERIOD_START=1, 5 move strobes from (320,240) dir 11 -> (325,245), bounce never 1, bounce_cnt=0.
- PERIOD_START=4: 8 move strobes -> exactly 2 steps, position (322,242).
- Wall column at x=331 (HALF=10, ball x=320) spanning rows 200..280, dir 11 -> next step xdir=0, xloc=319, yloc=241, bounce pulse, bounce_cnt=1, period 4→3.
- Single pixel at (331,251) only, dir 11 -> corner: xdir=0, ydir=0, position (319,239).
- 300 forced bounces -> bounce_cnt=255, period=PERIOD_MIN.
- Assert rst during a step -> outputs equal reset values, rings zero, no bounce pulse.
